rc_group_scheduler: RTL and testbench

Sequencer that feeds the redundancy controller. For each column window (step), it walks all FH·FW kernel indices in groups of GROUP_SIZE rows. For every group it fetches the LIFM columns from the LIFM buffer memory, streams them with their kernel indices into the redundancy controller, waits for its result, and clears it for the next group. It sits between the LIFM buffer memory and the redundancy controller and is the only master of both.

---
 rtl/rc_pkg.sv | 24 ++
 rtl/rc_addr_gen.sv | 96 +++++++++
 rtl/rc_group_scheduler.sv | 163 ++++++++++++++++
 tb/tb_rc_group_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc_pkg.sv
// Shared types and default constants for the redundancy-controller group scheduler.
// Latency: none (package only).
// Backpressure: none (package only).
package rc_pkg;

    // Defaults shared with the redundancy controller; GROUP_SIZE matches its MAX_LIFM_RSIZ.
    localparam int RC_WORD_WIDTH = 8;
    localparam int RC_STEP_RANGE = 128;
    localparam int RC_GROUP_SIZE = 3;
    localparam int RC_ADDR_WIDTH = 16;

    // Kernel index presented on pad slots of a partial last group.
    localparam logic [RC_WORD_WIDTH-1:0] PAD_KIDX = '1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WAIT_RC,
        CLEAR,
        DONE
    } rc_state_e;

endpackage

// File: rtl/rc_addr_gen.sv
// Step / group-base / slot counters with step*K + kidx read address and pad flag.
// Latency: address, kidx and pad are combinational from the counter flops.
// Backpressure: counters move only on slot_adv / grp_adv from the FSM; clr wins.
// Ports: clr restarts all counters; slot_adv steps the issue slot; grp_adv moves to the
// next group (and step on wrap); k / num_steps are the latched job geometry; outputs
// give the current slot's kidx, pad flag, read address, group index and last-group flag.
module rc_addr_gen
    import rc_pkg::*;
#(
    parameter int WORD_WIDTH = RC_WORD_WIDTH,
    parameter int GROUP_SIZE = RC_GROUP_SIZE,
    parameter int ADDR_WIDTH = RC_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  slot_adv,
    input  logic                  grp_adv,
    input  logic [WORD_WIDTH-1:0] k,
    input  logic [WORD_WIDTH-1:0] num_steps,
    output logic                  slot_last,
    output logic                  pad,
    output logic                  last_group,
    output logic [WORD_WIDTH-1:0] kidx,
    output logic [WORD_WIDTH-1:0] grp_idx,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam int SLOT_W = $clog2(GROUP_SIZE + 1);
    localparam int SUM_W  = ADDR_WIDTH + 2 * WORD_WIDTH + 1;

    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [WORD_WIDTH-1:0]   grp_base_q, grp_base_d;
    logic [WORD_WIDTH-1:0]   grp_idx_q, grp_idx_d;
    logic [WORD_WIDTH-1:0]   step_q, step_d;
    logic [WORD_WIDTH:0]     kidx_w, base_nxt, step_nxt;
    logic [2*WORD_WIDTH-1:0] step_k;
    logic [SUM_W-1:0]        addr_w;
    logic                    base_wrap;

    always_comb begin
        // One extra bit so grp_base + slot never aliases below K near the top of the range.
        kidx_w    = {1'b0, grp_base_q} + (WORD_WIDTH + 1)'(slot_q);
        pad       = kidx_w >= {1'b0, k};
        kidx      = kidx_w[WORD_WIDTH-1:0];
        step_k    = {{WORD_WIDTH{1'b0}}, step_q} * {{WORD_WIDTH{1'b0}}, k};
        addr_w    = SUM_W'(step_k) + SUM_W'(kidx_w);
        addr      = addr_w[ADDR_WIDTH-1:0];
        slot_last = slot_q == SLOT_W'(GROUP_SIZE - 1);
        base_nxt  = {1'b0, grp_base_q} + (WORD_WIDTH + 1)'(GROUP_SIZE);
        base_wrap = base_nxt >= {1'b0, k};
        step_nxt  = {1'b0, step_q} + (WORD_WIDTH + 1)'(1);
        last_group = base_wrap && (step_nxt >= {1'b0, num_steps});
        grp_idx   = grp_idx_q;

        slot_d     = slot_q;
        grp_base_d = grp_base_q;
        grp_idx_d  = grp_idx_q;
        step_d     = step_q;
        if (clr) begin
            slot_d     = '0;
            grp_base_d = '0;
            grp_idx_d  = '0;
            step_d     = '0;
        end else begin
            if (slot_adv) begin
                slot_d = slot_last ? '0 : slot_q + SLOT_W'(1);
            end
            if (grp_adv) begin
                if (base_wrap) begin
                    grp_base_d = '0;
                    grp_idx_d  = '0;
                    step_d     = step_nxt[WORD_WIDTH-1:0];
                end else begin
                    grp_base_d = base_nxt[WORD_WIDTH-1:0];
                    grp_idx_d  = grp_idx_q + WORD_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q     <= '0;
            grp_base_q <= '0;
            grp_idx_q  <= '0;
            step_q     <= '0;
        end else begin
            slot_q     <= slot_d;
            grp_base_q <= grp_base_d;
            grp_idx_q  <= grp_idx_d;
            step_q     <= step_d;
        end
    end

endmodule

// File: rtl/rc_group_scheduler.sv
// Sequencer feeding LIFM columns and kernel indices to the redundancy controller per group.
// Latency: first rd_en 1 cycle after start, rc_enable 1 cycle after each read strobe.
// Backpressure: holds in WAIT_RC until rc_valid; start ignored while busy; abort returns to IDLE.
// Ports: start/abort/cfg_* control a job; rd_* drive the LIFM buffer (data 1 cycle later);
// rc_* drive and clear the redundancy controller; busy/done/grp_idx report progress.
module rc_group_scheduler
    import rc_pkg::*;
#(
    parameter int WORD_WIDTH = RC_WORD_WIDTH,
    parameter int STEP_RANGE = RC_STEP_RANGE,
    parameter int GROUP_SIZE = RC_GROUP_SIZE,
    parameter int ADDR_WIDTH = RC_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic [WORD_WIDTH-1:0]            cfg_ke_width,
    input  logic [WORD_WIDTH-1:0]            cfg_ke_height,
    input  logic [WORD_WIDTH-1:0]            cfg_num_steps,
    output logic                             rd_en,
    output logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic [WORD_WIDTH*STEP_RANGE-1:0] rd_data,
    output logic                             rc_enable,
    output logic [WORD_WIDTH-1:0]            rc_kidx,
    output logic [WORD_WIDTH*STEP_RANGE-1:0] rc_lifm_column,
    input  logic                             rc_valid,
    output logic                             rc_clear,
    output logic                             busy,
    output logic                             done,
    output logic [WORD_WIDTH-1:0]            grp_idx
);

    rc_state_e               state_q, state_d;
    logic [WORD_WIDTH-1:0]   k_q, k_d;
    logic [WORD_WIDTH-1:0]   num_steps_q, num_steps_d;
    logic                    rc_enable_q, rc_enable_d;
    logic                    pad_q, pad_d;
    logic [WORD_WIDTH-1:0]   rc_kidx_q, rc_kidx_d;
    logic                    abort_clr_q, abort_clr_d;
    logic [2*WORD_WIDTH-1:0] k_full;
    logic                    empty;
    logic                    ag_clr, ag_slot_adv, ag_grp_adv;
    logic                    ag_slot_last, ag_pad, ag_last_group;
    logic [WORD_WIDTH-1:0]   ag_kidx, ag_grp_idx;
    logic [ADDR_WIDTH-1:0]   ag_addr;

    rc_addr_gen #(
        .WORD_WIDTH (WORD_WIDTH),
        .GROUP_SIZE (GROUP_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .clr        (ag_clr),
        .slot_adv   (ag_slot_adv),
        .grp_adv    (ag_grp_adv),
        .k          (k_q),
        .num_steps  (num_steps_q),
        .slot_last  (ag_slot_last),
        .pad        (ag_pad),
        .last_group (ag_last_group),
        .kidx       (ag_kidx),
        .grp_idx    (ag_grp_idx),
        .addr       (ag_addr)
    );

    always_comb begin
        k_full = {{WORD_WIDTH{1'b0}}, cfg_ke_height} * {{WORD_WIDTH{1'b0}}, cfg_ke_width};
        // A job with no kernel positions or no steps passes through ISSUE once without traffic.
        empty  = (k_q == '0) || (num_steps_q == '0);

        state_d     = state_q;
        k_d         = k_q;
        num_steps_d = num_steps_q;
        rc_enable_d = 1'b0;
        pad_d       = 1'b0;
        rc_kidx_d   = '0;
        abort_clr_d = 1'b0;
        ag_clr      = 1'b0;
        ag_slot_adv = 1'b0;
        ag_grp_adv  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ISSUE;
                    k_d         = k_full[WORD_WIDTH-1:0];
                    num_steps_d = cfg_num_steps;
                    ag_clr      = 1'b1;
                end
            end
            ISSUE: begin
                if (empty) begin
                    state_d = DONE;
                end else begin
                    // Pad slots still occupy a burst cycle so the controller sees GROUP_SIZE beats.
                    rc_enable_d = 1'b1;
                    pad_d       = ag_pad;
                    rc_kidx_d   = ag_pad ? WORD_WIDTH'(PAD_KIDX) : ag_kidx;
                    ag_slot_adv = 1'b1;
                    if (ag_slot_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN:   state_d = WAIT_RC;
            WAIT_RC: if (rc_valid) state_d = CLEAR;
            CLEAR: begin
                ag_grp_adv = 1'b1;
                state_d    = ag_last_group ? DONE : ISSUE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort drops any in-flight beat and clears the controller on the way back to IDLE.
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            rc_enable_d = 1'b0;
            pad_d       = 1'b0;
            rc_kidx_d   = '0;
            abort_clr_d = 1'b1;
            ag_clr      = 1'b1;
            ag_slot_adv = 1'b0;
            ag_grp_adv  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            num_steps_q <= '0;
            rc_enable_q <= 1'b0;
            pad_q       <= 1'b0;
            rc_kidx_q   <= '0;
            abort_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            num_steps_q <= num_steps_d;
            rc_enable_q <= rc_enable_d;
            pad_q       <= pad_d;
            rc_kidx_q   <= rc_kidx_d;
            abort_clr_q <= abort_clr_d;
        end
    end

    always_comb begin
        busy      = state_q != IDLE;
        done      = state_q == DONE;
        rc_clear  = (state_q == CLEAR) || abort_clr_q;
        rd_en     = (state_q == ISSUE) && !empty && !ag_pad;
        rd_addr   = rd_en ? ag_addr : '0;
        rc_enable = rc_enable_q;
        rc_kidx   = rc_kidx_q;
        grp_idx   = ag_grp_idx;
        // Read data lands one cycle after rd_en, aligned with the registered beat; gated otherwise.
        rc_lifm_column = (rc_enable_q && !pad_q) ? rd_data : '0;
    end

endmodule

// File: tb/tb_rc_group_scheduler.sv
module tb_rc_group_scheduler;

    localparam int WW = 8;
    localparam int SR = 128;
    localparam int GS = 3;
    localparam int AW = 16;
    localparam int CW = WW * SR;
    localparam int RC_LAT = 4;

    typedef struct {
        int kidx;
        int addr;   // -1 marks a pad beat (zero column expected)
        int grp;
    } rc_exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [WW-1:0] cfg_ke_width = '0;
    logic [WW-1:0] cfg_ke_height = '0;
    logic [WW-1:0] cfg_num_steps = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_data = '0;
    logic          rc_enable;
    logic [WW-1:0] rc_kidx;
    logic [CW-1:0] rc_lifm_column;
    logic          rc_valid = 1'b0;
    logic          rc_clear;
    logic          busy;
    logic          done;
    logic [WW-1:0] grp_idx;

    int      n_vec = 0;
    int      n_err = 0;
    int      exp_addr[$];
    rc_exp_t exp_rc[$];
    int      clr_cnt = 0;
    int      done_cnt = 0;
    bit      rsp_en = 1'b1;
    bit      rc_force = 1'b0;

    always #5 clk = ~clk;

    rc_group_scheduler #(
        .WORD_WIDTH (WW),
        .STEP_RANGE (SR),
        .GROUP_SIZE (GS),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .cfg_ke_width   (cfg_ke_width),
        .cfg_ke_height  (cfg_ke_height),
        .cfg_num_steps  (cfg_num_steps),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rc_enable      (rc_enable),
        .rc_kidx        (rc_kidx),
        .rc_lifm_column (rc_lifm_column),
        .rc_valid       (rc_valid),
        .rc_clear       (rc_clear),
        .busy           (busy),
        .done           (done),
        .grp_idx        (grp_idx)
    );

    function automatic logic [CW-1:0] mem_col(input int a);
        logic [CW-1:0] c;
        for (int i = 0; i < SR; i++) c[i*WW +: WW] = 8'(a * 5 + i + 90);
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // LIFM buffer: registered read, data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem_col(int'(rd_addr));
    end

    // Controller stand-in: rc_valid RC_LAT cycles after the last rc_enable of a burst.
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rc_enable) cnt = RC_LAT;
            else if (cnt != 0) cnt = cnt - 1;
            @(posedge clk);
            #1;
            rc_valid = ((cnt == 1) && rsp_en) || rc_force;
        end
    end

    // Scoreboard monitor: pops expectations whenever the DUT presents a read or a beat.
    initial begin : monitor
        int            a;
        rc_exp_t       e;
        logic [CW-1:0] ec;
        forever begin
            @(negedge clk);
            if (rd_en) begin
                if (exp_addr.size() == 0) chk("rd_unexpected", 32'(rd_en), 32'd0);
                else begin
                    a = exp_addr.pop_front();
                    chk("rd_addr", 32'(rd_addr), 32'(a));
                end
            end
            if (rc_enable) begin
                if (exp_rc.size() == 0) chk("rc_unexpected", 32'(rc_enable), 32'd0);
                else begin
                    e  = exp_rc.pop_front();
                    ec = (e.addr < 0) ? '0 : mem_col(e.addr);
                    chk("rc_kidx", 32'(rc_kidx), 32'(e.kidx));
                    chk("grp_idx", 32'(grp_idx), 32'(e.grp));
                    n_vec++;
                    if (rc_lifm_column !== ec) begin
                        n_err++;
                        $display("FAIL rc_column: got low word 0x%0h expected 0x%0h at %0t",
                                 rc_lifm_column[31:0], ec[31:0], $time);
                    end
                end
            end
            if (rc_clear) clr_cnt++;
            if (done) done_cnt++;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got %0d vectors expected completion", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic push_rd(input int a);
        exp_addr.push_back(a);
    endtask

    task automatic push_rc(input int kidx, input int addr, input int grp);
        rc_exp_t e;
        e.kidx = kidx;
        e.addr = addr;
        e.grp  = grp;
        exp_rc.push_back(e);
    endtask

    // Leaves the bench 1 ns into cycle 1 (cycle 0 = start sampled); cfg then scrambled.
    task automatic start_job(input int fw, input int fh, input int ns);
        step();
        cfg_ke_width  = 8'(fw);
        cfg_ke_height = 8'(fh);
        cfg_num_steps = 8'(ns);
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_ke_width  = 8'hEE;
        cfg_ke_height = 8'hEE;
        cfg_num_steps = 8'hEE;
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        step();
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic push_t1();
        push_rd(0); push_rd(1); push_rd(2);
        push_rc(0, 0, 0); push_rc(1, 1, 0); push_rc(2, 2, 0);
    endtask

    task automatic check_drained(input string nm);
        chk({nm, "_rd_q_left"}, 32'(exp_addr.size()), 32'd0);
        chk({nm, "_rc_q_left"}, 32'(exp_rc.size()), 32'd0);
    endtask

    task automatic run_zero(input int fw, input int fh, input int ns);
        int d0;
        d0 = done_cnt;
        start_job(fw, fh, ns);
        @(negedge clk);
        chk("zero_busy_c1", 32'(busy), 32'd1);
        chk("zero_done_c1", 32'(done), 32'd0);
        step();
        @(negedge clk);
        chk("zero_done_c2", 32'(done), 32'd1);
        step();
        @(negedge clk);
        chk("zero_busy_c3", 32'(busy), 32'd0);
        chk("zero_done_cnt", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_rd_en"}, 32'(rd_en), 32'd0);
        chk({nm, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({nm, "_rc_enable"}, 32'(rc_enable), 32'd0);
        chk({nm, "_rc_kidx"}, 32'(rc_kidx), 32'd0);
        chk({nm, "_rc_col_nz"}, 32'(|rc_lifm_column), 32'd0);
        chk({nm, "_rc_clear"}, 32'(rc_clear), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_grp_idx"}, 32'(grp_idx), 32'd0);
    endtask

    // FW=2, FH=2, two steps: groups {0,1,2},{3,pad,pad} per step.
    int t2_addr[8]  = '{0, 1, 2, 3, 4, 5, 6, 7};
    int t2_kidx[12] = '{0, 1, 2, 3, 255, 255, 0, 1, 2, 3, 255, 255};
    int t2_col[12]  = '{0, 1, 2, 3, -1, -1, 4, 5, 6, 7, -1, -1};
    int t2_grp[12]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};

    initial begin : stim
        int c0, d0;

        // Reset state
        step(); step(); step();
        @(negedge clk);
        check_all_zero("reset");
        step();
        reset = 1'b0;

        // T1: K = 3, one step; first read in cycle 1, first beat in cycle 2
        push_t1();
        c0 = clr_cnt; d0 = done_cnt;
        start_job(3, 1, 1);
        @(negedge clk);
        chk("t1_rd_en_c1", 32'(rd_en), 32'd1);
        chk("t1_rc_en_c1", 32'(rc_enable), 32'd0);
        @(negedge clk);
        chk("t1_rc_en_c2", 32'(rc_enable), 32'd1);
        wait_done(100);
        chk("t1_clears", 32'(clr_cnt - c0), 32'd1);
        chk("t1_dones", 32'(done_cnt - d0), 32'd1);
        check_drained("t1");

        // T2: K = 4, two steps, partial last group with pads
        foreach (t2_addr[i]) push_rd(t2_addr[i]);
        foreach (t2_kidx[i]) push_rc(t2_kidx[i], t2_col[i], t2_grp[i]);
        c0 = clr_cnt; d0 = done_cnt;
        start_job(2, 2, 2);
        wait_done(300);
        chk("t2_clears", 32'(clr_cnt - c0), 32'd4);
        chk("t2_dones", 32'(done_cnt - d0), 32'd1);
        check_drained("t2");

        // T3: degenerate jobs
        run_zero(3, 1, 0);
        run_zero(0, 5, 3);

        // T4: abort while waiting for the controller, then replay
        rsp_en = 1'b0;
        push_t1();
        c0 = clr_cnt; d0 = done_cnt;
        start_job(3, 1, 1);
        step(); step(); step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rc_clear", 32'(rc_clear), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 6; i++) step();
        chk("abort_clears", 32'(clr_cnt - c0), 32'd1);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check_drained("abort");
        rsp_en = 1'b1;
        push_t1();
        start_job(3, 1, 1);
        wait_done(100);
        check_drained("replay");

        // T5: reset during ISSUE; late read data must not reach the controller
        push_rd(0);
        c0 = clr_cnt;
        start_job(3, 1, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        for (int i = 0; i < 6; i++) step();
        chk("midreset_no_clear", 32'(clr_cnt - c0), 32'd0);
        check_drained("midreset");
        push_t1();
        start_job(3, 1, 1);
        wait_done(100);
        check_drained("post_reset");

        // T6: rc_valid high in IDLE and ISSUE, extra start while busy
        rc_force = 1'b1;
        step(); step(); step();
        @(negedge clk);
        chk("idle_rcv_busy", 32'(busy), 32'd0);
        push_t1();
        c0 = clr_cnt; d0 = done_cnt;
        start_job(3, 1, 1);
        step();
        cfg_ke_width = 8'd2; cfg_ke_height = 8'd2; cfg_num_steps = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        rc_force = 1'b0;
        wait_done(100);
        chk("t6_clears", 32'(clr_cnt - c0), 32'd1);
        chk("t6_dones", 32'(done_cnt - d0), 32'd1);
        check_drained("t6");

        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
